// File: rtl/icache_dm_pkg.sv
// Shared constants, address-field slice macros and FSM encoding for the
// direct-mapped instruction cache.
`ifndef ICACHE_DM_DEFS
`define ICACHE_DM_DEFS
`define ICACHE_TAG(a, aw, tw) a[(aw)-1 -: (tw)]
`define ICACHE_IDX(a, ow, iw) a[(ow) +: (iw)]
`define ICACHE_OFF(a, ow)     a[(ow)-1:0]
`endif

package icache_dm_pkg;

  localparam int unsigned ICACHE_SETS      = 32;
  localparam int unsigned ICACHE_LINE_PKTS = 2;
  localparam int unsigned ICACHE_ADDR_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/icache_dm_ram.sv
// Tag and line data arrays: one synchronous read port returning a tag and one
// 64-bit packet, one whole-line write port.
module icache_ram #(
  parameter int unsigned SETS      = 32,
  parameter int unsigned LINE_PKTS = 2,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned IDX_W     = $clog2(SETS),
  parameter int unsigned OFF_W     = $clog2(LINE_PKTS)
) (
  input  logic                    clk_i,
  input  logic                    rd_en_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  input  logic [OFF_W-1:0]        rd_off_i,
  output logic [TAG_W-1:0]        rd_tag_o,
  output logic [63:0]             rd_pkt_o,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [TAG_W-1:0]        wr_tag_i,
  input  logic [64*LINE_PKTS-1:0] wr_line_i
);

  logic [TAG_W-1:0]        tag_q  [SETS];
  logic [64*LINE_PKTS-1:0] line_q [SETS];
  logic [TAG_W-1:0]        rd_tag_q;
  logic [63:0]             rd_pkt_q;

  // Write-first: a lookup issued on the fill edge must see the new tag,
  // otherwise the old tag plus the freshly set valid bit would false-hit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      line_q[wr_idx_i] <= wr_line_i;
    end
    if (rd_en_i) begin
      if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
        rd_tag_q <= wr_tag_i;
        rd_pkt_q <= wr_line_i[{rd_off_i, 6'b0} +: 64];
      end else begin
        rd_tag_q <= tag_q[rd_idx_i];
        rd_pkt_q <= line_q[rd_idx_i][{rd_off_i, 6'b0} +: 64];
      end
    end
  end

  assign rd_tag_o = rd_tag_q;
  assign rd_pkt_o = rd_pkt_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 1-cycle pipelined hits, blocking refill of
// a whole line over a 32-bit req/ack bus.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned SETS      = ICACHE_SETS,
  parameter int unsigned LINE_PKTS = ICACHE_LINE_PKTS,
  parameter int unsigned ADDR_W    = ICACHE_ADDR_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              re_i,
  input  logic              flush_i,
  output logic [63:0]       data_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W:0]   mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned OFF_W  = $clog2(LINE_PKTS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BEAT_W = OFF_W + 1;
  localparam int unsigned LINE_W = 64 * LINE_PKTS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * LINE_PKTS - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   req_q;
  logic                lookup_q;
  logic                flush_pend_q;
  logic                mem_req_q;
  logic [SETS-1:0]     valid_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [LINE_W-1:0]   line_q;
  logic [63:0]         pkt_q;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_off;
  logic [TAG_W-1:0]    rd_tag;
  logic [63:0]         rd_pkt;
  logic [63:0]         line_pkt;
  logic                hit;
  logic                stall;
  logic                fetch;
  logic                fill_we;

  assign req_tag = `ICACHE_TAG(req_q, ADDR_W, TAG_W);
  assign req_idx = `ICACHE_IDX(req_q, OFF_W, IDX_W);
  assign req_off = `ICACHE_OFF(req_q, OFF_W);

  icache_ram #(
    .SETS      (SETS),
    .LINE_PKTS (LINE_PKTS),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W),
    .OFF_W     (OFF_W)
  ) u_ram (
    .clk_i     (clock_i),
    .rd_en_i   (fetch),
    .rd_idx_i  (`ICACHE_IDX(addr_i, OFF_W, IDX_W)),
    .rd_off_i  (`ICACHE_OFF(addr_i, OFF_W)),
    .rd_tag_o  (rd_tag),
    .rd_pkt_o  (rd_pkt),
    .wr_en_i   (fill_we),
    .wr_idx_i  (req_idx),
    .wr_tag_i  (req_tag),
    .wr_line_i (line_q)
  );

  always_comb begin
    hit      = lookup_q & valid_q[req_idx] & (rd_tag == req_tag);
    line_pkt = line_q[{req_off, 6'b0} +: 64];
    stall    = 1'b0;
    data_o   = pkt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lookup_q) begin
          stall  = ~hit;
          data_o = hit ? rd_pkt : '0;
        end
      end
      ST_REFILL: begin
        stall  = 1'b1;
        data_o = '0;
      end
      ST_DONE: data_o = line_pkt;
      default: ;
    endcase
    fetch   = re_i & ~stall;
    fill_we = (state_q == ST_DONE) & ~reset_i;
  end

  assign stall_o    = stall;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = {req_tag, req_idx, beat_q};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      lookup_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      valid_q      <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      pkt_q        <= '0;
    end else begin
      if (fetch) begin
        req_q <= addr_i;
      end
      lookup_q <= fetch;
      unique case (state_q)
        ST_IDLE: begin
          if (lookup_q) begin
            if (hit) begin
              pkt_q <= rd_pkt;
            end else begin
              pkt_q     <= '0;
              beat_q    <= '0;
              mem_req_q <= 1'b1;
              state_q   <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (flush_i) begin
            flush_pend_q <= 1'b1;
          end
          if (mem_req_q && mem_ack_i) begin
            line_q[{beat_q, 5'b0} +: 32] <= mem_data_i;
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              mem_req_q <= 1'b0;
              state_q   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          pkt_q        <= line_pkt;
          flush_pend_q <= 1'b0;
          state_q      <= ST_IDLE;
          if (!flush_pend_q) begin
            valid_q[req_idx] <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // A flush on this edge outranks the fill's valid-bit set above.
      if (flush_i) begin
        valid_q <= '0;
      end
    end
  end

endmodule
